game_phase_sequencer: RTL and testbench
=======================================

Name: game_phase_sequencer

Overview:
Parametrised successor to the blackjack-board game control FSM. Turns active-low push-button releases into phase transitions: begin, block select, block set (looped N times), play, run, end. Emits level and one-cycle load strobes to the game datapath and keeps win/loss scores for the hex displays. Sits between the KEY inputs and the datapath/VGA draw logic.

Parameters:
MAX_BLOCKS, 4, upper bound on blocks placed per round (1..15)
CNT_W, 4, width of block counters
DEBOUNCE_CYCLES, 16, stable-sample count required per key; used only with DEBOUNCE_EN

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high
key_n  in  4  raw active-low keys: [0]=begin/end, [1]=block, [2]=set, [3]=play
num_blocks  in  CNT_W  requested blocks per round, sampled in BEGIN
game_done  in  1  one-cycle pulse from game engine: round finished
game_win  in  1  result, valid with game_done
phase  out  3  encoded current state
ld_begin, ld_block, ld_set, ld_play, ld_run, ld_end  out  1 each  level, high while in that state
set_pulse  out  1  one cycle on each accepted set
round_done_pulse  out  1  one cycle on RUN->END
blocks_used  out  CNT_W  blocks placed this round
blocks_target  out  CNT_W  latched target
wins, losses  out  4 each  BCD scores, saturate at 9

Behaviour:
- Always: key_n passes through a 2-flop synchroniser that resets to 4'b1111. A release event is sync_prev=0 and sync_now=1. Presses do not advance; releases do.
- In each state only that state's key is evaluated. Releases on other keys are discarded, including simultaneous ones.
- Reset: phase=BEGIN, blocks_used=0, blocks_target=1, wins=losses=0, all pulses 0. Reset takes effect from any state, mid-round included.
- BEGIN (0): each cycle, blocks_target <= clamp(num_blocks), where 0 maps to 1 and values >MAX_BLOCKS map to MAX_BLOCKS. blocks_used <= 0. Release of key[0] -> BLOCK.
- BLOCK (1): release of key[1] -> SET.
- SET (2): release of key[2]:
  - set_pulse=1 the same cycle.
  - blocks_used <= blocks_used+1.
  - If blocks_used+1 == blocks_target -> PLAY, else -> BLOCK.
  - blocks_used never exceeds blocks_target.
- PLAY (3): release of key[3] -> RUN.
- RUN (4): waits for game_done. On game_done, game_win=1 increments wins, else increments losses; both saturate at 9. round_done_pulse=1 that cycle, then -> END. game_done in any other state is ignored.
- END (5): release of key[0] -> BEGIN. Scores persist across rounds and are cleared only by reset.
- Codes 6 and 7 are illegal and go to BEGIN on the next cycle.
- Latency: release edge at the pin -> phase change 3 cycles later (2 sync + 1 state register).
- ld_* outputs are decoded combinationally from the phase register.
- num_blocks changes outside BEGIN have no effect.

Optional Feature:
DEBOUNCE_EN
- Defined: each synchronised key must hold a new level for DEBOUNCE_CYCLES consecutive cycles before its filtered level updates. The release event is taken from the filtered level. Glitches shorter than DEBOUNCE_CYCLES are rejected, and latency grows by DEBOUNCE_CYCLES.
- Undefined: no filter; the DEBOUNCE_CYCLES parameter is ignored.

Decomposition:
- Package game_seq_pkg: phase encodings (PH_BEGIN..PH_END, width 3), key index constants (KEY_BEGIN=0, KEY_BLOCK=1, KEY_SET=2, KEY_PLAY=3), SCORE_MAX=9.
- Sub-module key_release_detect, instantiated per key: synchroniser, optional debounce counter, release strobe output.
- FSM and score counters stay in the top.

Test Plan:
- Reset with num_blocks=3: release key0, then key1/key2 three times -> blocks_used reaches 3, set_pulse fires 3 times, phase=PLAY after the 3rd set.
- num_blocks=0 -> blocks_target=1; num_blocks=12 with MAX_BLOCKS=4 -> blocks_target=4, PLAY after 4 sets.
- In BLOCK, release key2 and key3 simultaneously with key1 -> only key1 is honoured, phase=SET, blocks_used unchanged.
- Ten RUN rounds each ending in game_done with game_win=1 -> wins=9 (saturated), losses=0; game_done pulsed in PLAY -> no score change.
- Assert reset in SET with blocks_used=2 -> next cycle phase=BEGIN, blocks_used=0, wins=losses=0.
- With DEBOUNCE_EN and DEBOUNCE_CYCLES=16: a 10-cycle key1 low glitch -> no transition; a 20-cycle press then release -> phase=SET after 16+3 cycles.

Source files
------------

// File: rtl/game_seq_pkg.sv
// game_seq_pkg
// Shared definitions for the game phase sequencer: phase encodings,
// key index constants and the BCD score ceiling.
package game_seq_pkg;

  typedef enum logic [2:0] {
    PH_BEGIN = 3'd0,
    PH_BLOCK = 3'd1,
    PH_SET   = 3'd2,
    PH_PLAY  = 3'd3,
    PH_RUN   = 3'd4,
    PH_END   = 3'd5
  } phase_e;

  localparam int KEY_BEGIN = 0;
  localparam int KEY_BLOCK = 1;
  localparam int KEY_SET   = 2;
  localparam int KEY_PLAY  = 3;

  localparam logic [3:0] SCORE_MAX = 4'd9;

  // Single-digit BCD increment that sticks at 9.
  function automatic logic [3:0] score_inc(input logic [3:0] score);
    return (score >= SCORE_MAX) ? SCORE_MAX : score + 4'd1;
  endfunction

endpackage

// File: rtl/key_release_detect.sv
// key_release_detect
// One push-button: 2-flop synchroniser, optional debounce filter, and a
// one-cycle release strobe (level goes 0 -> 1, i.e. button let go).
// Optional feature macro: DEBOUNCE_EN (filter present when defined).
// Ports:
//   clk         system clock
//   reset       synchronous, active-high
//   key_n       raw active-low key
//   release_evt one-cycle strobe on release
module key_release_detect #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic release_evt
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic sync_a;
  logic sync_now;
  logic level;
  logic level_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a   <= 1'b1;
      sync_now <= 1'b1;
    end else begin
      sync_a   <= key_n;
      sync_now <= sync_a;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] hold_cnt;
  logic          filt;

  // Down-counter runs only while the synchronised level disagrees with the
  // filtered level; any bounce back reloads it, so the new level must be
  // stable for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt     <= 1'b1;
      hold_cnt <= RELOAD;
    end else if (sync_now == filt) begin
      hold_cnt <= RELOAD;
    end else if (hold_cnt == '0) begin
      filt     <= sync_now;
      hold_cnt <= RELOAD;
    end else begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  assign level = filt;
`else
  assign level = sync_now;
`endif

  always_ff @(posedge clk) begin
    if (reset) level_prev <= 1'b1;
    else       level_prev <= level;
  end

  assign release_evt = ~level_prev & level;

endmodule

// File: rtl/game_phase_sequencer.sv
// game_phase_sequencer
// Turns push-button releases into game phases, drives datapath load
// levels/strobes and keeps saturating BCD win/loss scores.
// Optional feature macro: DEBOUNCE_EN (per-key debounce filter).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   key_n[3:0]            raw active-low keys (begin/end, block, set, play)
//   num_blocks            requested blocks per round, sampled in BEGIN
//   game_done, game_win   round-finished pulse and its result
//   phase                 encoded current phase
//   ld_*                  level, high while in the matching phase
//   set_pulse             one cycle per accepted set
//   round_done_pulse      one cycle on RUN -> END
//   blocks_used/target    block count this round and its latched target
//   wins, losses          BCD scores, saturate at 9
//
// state | meaning
// BEGIN | latch clamped target, clear block count, wait key0 release
// BLOCK | wait key1 release (select a block)
// SET   | wait key2 release (place block), loop until target reached
// PLAY  | wait key3 release
// RUN   | wait game_done, score the round
// END   | wait key0 release to start the next round
module game_phase_sequencer
  import game_seq_pkg::*;
#(
  parameter int MAX_BLOCKS      = 4,
  parameter int CNT_W           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       key_n,
  input  logic [CNT_W-1:0] num_blocks,
  input  logic             game_done,
  input  logic             game_win,
  output logic [2:0]       phase,
  output logic             ld_begin,
  output logic             ld_block,
  output logic             ld_set,
  output logic             ld_play,
  output logic             ld_run,
  output logic             ld_end,
  output logic             set_pulse,
  output logic             round_done_pulse,
  output logic [CNT_W-1:0] blocks_used,
  output logic [CNT_W-1:0] blocks_target,
  output logic [3:0]       wins,
  output logic [3:0]       losses
);

  if (MAX_BLOCKS < 1 || MAX_BLOCKS >= (1 << CNT_W)) begin : g_bad_cfg
    $error("MAX_BLOCKS must fit in CNT_W bits and be at least 1");
  end

  localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BLOCKS);
  localparam logic [CNT_W-1:0] ONE_B = CNT_W'(1);

  logic [3:0] rel;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_release_detect #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk        (clk),
      .reset      (reset),
      .key_n      (key_n[k]),
      .release_evt(rel[k])
    );
  end

  phase_e           state;
  logic [CNT_W-1:0] target_clamped;
  logic [CNT_W-1:0] used_next;

  always_comb begin
    target_clamped = num_blocks;
    if (num_blocks == '0)        target_clamped = ONE_B;
    else if (num_blocks > MAX_B) target_clamped = MAX_B;
  end

  assign used_next = blocks_used + ONE_B;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= PH_BEGIN;
      blocks_used   <= '0;
      blocks_target <= ONE_B;
      wins          <= 4'd0;
      losses        <= 4'd0;
    end else begin
      case (state)
        PH_BEGIN: begin
          blocks_target <= target_clamped;
          blocks_used   <= '0;
          if (rel[KEY_BEGIN]) state <= PH_BLOCK;
        end
        PH_BLOCK: if (rel[KEY_BLOCK]) state <= PH_SET;
        PH_SET: begin
          if (rel[KEY_SET]) begin
            blocks_used <= used_next;
            // >= keeps the count from ever running past the target
            state <= (used_next >= blocks_target) ? PH_PLAY : PH_BLOCK;
          end
        end
        PH_PLAY: if (rel[KEY_PLAY]) state <= PH_RUN;
        PH_RUN: begin
          if (game_done) begin
            if (game_win) wins   <= score_inc(wins);
            else          losses <= score_inc(losses);
            state <= PH_END;
          end
        end
        PH_END: if (rel[KEY_BEGIN]) state <= PH_BEGIN;
        default: state <= PH_BEGIN;
      endcase
    end
  end

  assign phase    = state;
  assign ld_begin = (state == PH_BEGIN);
  assign ld_block = (state == PH_BLOCK);
  assign ld_set   = (state == PH_SET);
  assign ld_play  = (state == PH_PLAY);
  assign ld_run   = (state == PH_RUN);
  assign ld_end   = (state == PH_END);

  // Strobes coincide with the cycle the transition is taken.
  assign set_pulse        = (state == PH_SET) & rel[KEY_SET];
  assign round_done_pulse = (state == PH_RUN) & game_done;

endmodule

// File: tb/tb_game_phase_sequencer.sv
module tb_game_phase_sequencer;
  import game_seq_pkg::*;

`ifdef DEBOUNCE_EN
  localparam int HOLD = 20;
  localparam int LAT  = 19;
`else
  localparam int HOLD = 4;
  localparam int LAT  = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic [3:0] num_blocks = 4'd3;
  logic       game_done = 1'b0;
  logic       game_win = 1'b0;
  logic [2:0] phase;
  logic       ld_begin, ld_block, ld_set, ld_play, ld_run, ld_end;
  logic       set_pulse, round_done_pulse;
  logic [3:0] blocks_used, blocks_target, wins, losses;

  game_phase_sequencer #(
    .MAX_BLOCKS(4), .CNT_W(4), .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .num_blocks(num_blocks),
    .game_done(game_done), .game_win(game_win), .phase(phase),
    .ld_begin(ld_begin), .ld_block(ld_block), .ld_set(ld_set),
    .ld_play(ld_play), .ld_run(ld_run), .ld_end(ld_end),
    .set_pulse(set_pulse), .round_done_pulse(round_done_pulse),
    .blocks_used(blocks_used), .blocks_target(blocks_target),
    .wins(wins), .losses(losses)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] ph;
    logic [3:0] used;
    logic [3:0] tgt;
    logic [3:0] w;
    logic [3:0] l;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, failures = 0;
  int   trans_cnt = 0, set_seen = 0, rd_seen = 0;
  logic [2:0] last_ph = 3'd0;
  bit   mon_en = 1'b0;

  // model state
  logic [3:0] m_used = 0, m_tgt = 1, m_w = 0, m_l = 0;
  int         m_sets = 0, m_rds = 0;

  // Monitor: every phase change pops one expected record.
  always @(negedge clk) begin
    exp_t e;
    logic [5:0] ld, eld;
    if (mon_en) begin
      if (phase != last_ph) begin
        checks++;
        trans_cnt++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_transition phase %0d -> %0d at cycle %0d", last_ph, phase, cyc);
        end else begin
          e   = exp_q.pop_front();
          ld  = {ld_end, ld_run, ld_play, ld_set, ld_block, ld_begin};
          eld = 6'b1 << e.ph;
          if (phase !== e.ph || blocks_used !== e.used || blocks_target !== e.tgt ||
              wins !== e.w || losses !== e.l || ld !== eld || cyc != e.cyc) begin
            failures++;
            $display("FAIL transition got ph=%0d used=%0d tgt=%0d w=%0d l=%0d ld=%b cyc=%0d want ph=%0d used=%0d tgt=%0d w=%0d l=%0d ld=%b cyc=%0d",
                     phase, blocks_used, blocks_target, wins, losses, ld, cyc,
                     e.ph, e.used, e.tgt, e.w, e.l, eld, e.cyc);
          end
        end
      end
      if (set_pulse) set_seen++;
      if (round_done_pulse) rd_seen++;
    end
    last_ph = phase;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] clampb(input logic [3:0] n);
    if (n == 4'd0) return 4'd1;
    if (n > 4'd4) return 4'd4;
    return n;
  endfunction

  task automatic wait_trans(input int n0);
    for (int i = 0; i < LAT + 20; i++) begin
      if (trans_cnt > n0) return;
      @(negedge clk);
    end
    if (trans_cnt <= n0) begin
      checks++;
      failures++;
      $display("FAIL timeout waiting for transition at cycle %0d", cyc);
    end
  endtask

  task automatic step_key(input logic [3:0] mask, input logic [2:0] nph);
    exp_t e;
    int n0;
    @(negedge clk);
    key_n = ~mask;
    repeat (HOLD) @(negedge clk);
    e = '{nph, m_used, m_tgt, m_w, m_l, cyc + LAT};
    exp_q.push_back(e);
    n0 = trans_cnt;
    key_n = 4'hF;
    wait_trans(n0);
  endtask

  task automatic do_begin();
    m_tgt  = clampb(num_blocks);
    m_used = 0;
    step_key(4'b0001, PH_BLOCK);
  endtask

  task automatic do_block();
    step_key(4'b0010, PH_SET);
  endtask

  task automatic do_set();
    m_used = m_used + 1;
    m_sets++;
    step_key(4'b0100, (m_used == m_tgt) ? PH_PLAY : PH_BLOCK);
  endtask

  task automatic do_play();
    step_key(4'b1000, PH_RUN);
  endtask

  task automatic do_end();
    step_key(4'b0001, PH_BEGIN);
  endtask

  task automatic do_done(input logic win);
    exp_t e;
    int n0;
    @(negedge clk);
    if (win) m_w = (m_w == 4'd9) ? 4'd9 : m_w + 1;
    else     m_l = (m_l == 4'd9) ? 4'd9 : m_l + 1;
    m_rds++;
    e = '{PH_END, m_used, m_tgt, m_w, m_l, cyc + 1};
    exp_q.push_back(e);
    n0 = trans_cnt;
    game_done = 1'b1;
    game_win  = win;
    @(negedge clk);
    game_done = 1'b0;
    game_win  = 1'b0;
    wait_trans(n0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n0;
    repeat (3) @(negedge clk);
    chk("reset_phase", phase, 0);
    chk("reset_used", blocks_used, 0);
    chk("reset_target", blocks_target, 1);
    chk("reset_scores", {wins, losses}, 0);
    chk("reset_pulses", {set_pulse, round_done_pulse}, 0);
    chk("reset_ld_begin", ld_begin, 1);
    mon_en = 1'b1;
    reset  = 1'b0;

    // round with 3 blocks, lost
    do_begin();
    repeat (3) begin do_block(); do_set(); end
    chk("used_after_3_sets", blocks_used, 3);
    chk("sets_after_3", set_seen, 3);
    do_play();
    do_done(1'b0);
    do_end();

    // num_blocks=0 clamps to 1, won
    num_blocks = 4'd0;
    do_begin();
    chk("target_clamp_zero", blocks_target, 1);
    do_block();
    do_set();
    do_play();
    do_done(1'b1);
    do_end();

    // num_blocks=12 clamps to MAX_BLOCKS
    num_blocks = 4'd12;
    do_begin();
    chk("target_clamp_max", blocks_target, 4);
    num_blocks = 4'd2;  // outside BEGIN: must be ignored
    step_key(4'b1110, PH_SET);  // key1,2,3 released together in BLOCK
    do_set();
    repeat (3) begin do_block(); do_set(); end
    chk("used_after_4_sets", blocks_used, 4);
    chk("target_held", blocks_target, 4);

    // game_done in PLAY is ignored
    @(negedge clk);
    game_done = 1'b1;
    game_win  = 1'b1;
    @(negedge clk);
    game_done = 1'b0;
    game_win  = 1'b0;
    repeat (3) @(negedge clk);
    chk("play_done_wins", wins, 1);
    chk("play_done_losses", losses, 1);
    chk("play_done_phase", phase, PH_PLAY);

    // key0 release in PLAY is discarded
    @(negedge clk);
    key_n = 4'b1110;
    repeat (HOLD) @(negedge clk);
    key_n = 4'hF;
    repeat (LAT + 5) @(negedge clk);
    chk("wrong_key_phase", phase, PH_PLAY);

    do_play();
    do_done(1'b1);
    do_end();

    // wins saturate at 9
    num_blocks = 4'd1;
    repeat (9) begin
      do_begin(); do_block(); do_set(); do_play(); do_done(1'b1); do_end();
    end
    chk("wins_saturated", wins, 9);
    chk("losses_kept", losses, 1);

    // reset mid-round in SET with 2 blocks placed
    num_blocks = 4'd3;
    do_begin();
    do_block(); do_set();
    do_block(); do_set();
    do_block();
    chk("used_before_reset", blocks_used, 2);
    @(negedge clk);
    e = '{PH_BEGIN, 4'd0, 4'd1, 4'd0, 4'd0, cyc + 1};
    exp_q.push_back(e);
    n0 = trans_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_used = 0; m_tgt = 1; m_w = 0; m_l = 0;
    wait_trans(n0);
    chk("post_reset_scores", {wins, losses}, 0);

`ifdef DEBOUNCE_EN
    do_begin();
    n0 = trans_cnt;
    @(negedge clk);
    key_n = 4'b1101;
    repeat (10) @(negedge clk);
    key_n = 4'hF;
    repeat (40) @(negedge clk);
    chk("glitch_phase", phase, PH_BLOCK);
    chk("glitch_no_trans", trans_cnt, n0);
    do_block();
`endif

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("set_pulse_count", set_seen, m_sets);
    chk("round_done_count", rd_seen, m_rds);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
